// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters with decoded sync pulses, pixel coordinates and active-video flag.
// Define VGA_TIMING_SYNC_PIPE_EN to delay h_sync, v_sync, line_start and frame_start by one clock.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       frame_active,
    output logic       h_sync,
    output logic       v_sync,
    output logic       line_start,
    output logic       frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        H_POL      = (H_SYNC_POL != 0);
    localparam logic        V_POL      = (V_SYNC_POL != 0);

    if (H_TOTAL > 1024) begin : g_hTotalCheck
        $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_vTotalCheck
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end

    logic [9:0]  r_hCtr;
    logic [9:0]  r_vCtr;
    logic [10:0] w_hExt;
    logic [10:0] w_vExt;
    logic        w_hSyncOn;
    logic        w_vSyncOn;
    logic        w_hSync;
    logic        w_vSync;
    logic        w_lineStart;
    logic        w_frameStart;

    // Reset parks on the last pixel so the first edge after release lands on (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hCtr <= H_LAST;
            r_vCtr <= V_LAST;
        end else if (r_hCtr == H_LAST) begin
            r_hCtr <= '0;
            r_vCtr <= (r_vCtr == V_LAST) ? '0 : r_vCtr + 10'd1;
        end else begin
            r_hCtr <= r_hCtr + 10'd1;
        end
    end

    assign w_hExt       = {1'b0, r_hCtr};
    assign w_vExt       = {1'b0, r_vCtr};
    assign w_hSyncOn    = (w_hExt >= H_SYNC_BEG) && (w_hExt < H_SYNC_END);
    assign w_vSyncOn    = (w_vExt >= V_SYNC_BEG) && (w_vExt < V_SYNC_END);
    assign w_hSync      = w_hSyncOn ? H_POL : ~H_POL;
    assign w_vSync      = w_vSyncOn ? V_POL : ~V_POL;
    assign w_lineStart  = (r_hCtr == 10'd0);
    assign w_frameStart = w_lineStart && (r_vCtr == 10'd0);

    assign x            = r_hCtr;
    assign y            = r_vCtr[8:0];
    assign frame_active = (w_hExt < H_ACT_END) && (w_vExt < V_ACT_END);

`ifdef VGA_TIMING_SYNC_PIPE_EN
    logic r_hSync;
    logic r_vSync;
    logic r_lineStart;
    logic r_frameStart;

    // One-clock delay to line sync up with a registered RGB stage downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hSync      <= ~H_POL;
            r_vSync      <= ~V_POL;
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
        end else begin
            r_hSync      <= w_hSync;
            r_vSync      <= w_vSync;
            r_lineStart  <= w_lineStart;
            r_frameStart <= w_frameStart;
        end
    end

    assign h_sync      = r_hSync;
    assign v_sync      = r_vSync;
    assign line_start  = r_lineStart;
    assign frame_start = r_frameStart;
`else
    assign h_sync      = w_hSync;
    assign v_sync      = w_vSync;
    assign line_start  = w_lineStart;
    assign frame_start = w_frameStart;
`endif

endmodule
